// File: rtl/rules_grid_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rules_grid_seq
//  Description : Sequential fuzzy rule grid. Captures one frame of NT
//                temperature memberships and ND derivative memberships, then
//                streams every rule firing strength w(i,j) = tnorm(mu_t[i],
//                mu_d[j]) over a valid/ready handshake in row-major order.
//                The total of all weights of the frame is reported once the
//                last rule has been accepted, for downstream normalisation.
//
//  Parameters  : W     - membership / weight width (unsigned, full scale 2^W-1)
//                NT    - number of temperature fuzzy sets (1..8)
//                ND    - number of derivative fuzzy sets (1..8)
//                TNORM - 0 = min(a,b), 1 = floor(a*b / 2^W)
//                SW    - width of w_sum, derived, wide enough for NT*ND weights
//
//  Ports       : clk        in   clock
//                rst_n      in   synchronous active-low reset
//                in_valid   in   membership frame valid
//                in_ready   out  block can capture a frame (IDLE only)
//                mu_t       in   NT*W, set i at bits [i*W +: W]
//                mu_d       in   ND*W, set j at bits [j*W +: W]
//                out_valid  out  rule weight valid (RUN only)
//                out_ready  in   downstream accepts weight
//                out_w      out  weight w(i,j), 0 outside RUN
//                out_i      out  temperature set index i, 0 outside RUN
//                out_j      out  derivative set index j, 0 outside RUN
//                out_last   out  marks rule (NT-1, ND-1)
//                sum_valid  out  one-cycle pulse, w_sum holds the frame total
//                w_sum      out  sum of all NT*ND weights of the frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rules_grid_seq #(
    parameter  int W     = 16,
    parameter  int NT    = 3,
    parameter  int ND    = 3,
    parameter  int TNORM = 0,
    localparam int SW    = W + $clog2(NT * ND)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NT*W-1:0] mu_t,
    input  logic [ND*W-1:0] mu_d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_w,
    output logic [2:0]      out_i,
    output logic [2:0]      out_j,
    output logic            out_last,
    output logic            sum_valid,
    output logic [SW-1:0]   w_sum
);

    // Index of the final row / column, sized to the 3-bit index registers.
    localparam logic [2:0] I_LAST   = 3'(NT - 1);
    localparam logic [2:0] J_LAST   = 3'(ND - 1);
    // A 1x1 grid presents its only rule already flagged as last.
    localparam logic       ONE_RULE = ((NT == 1) && (ND == 1)) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              sum_valid_q;
    logic [2:0]        i_q;
    logic [2:0]        j_q;
    logic [SW-1:0]     acc_q;
    logic [NT*W-1:0]   mu_t_q;
    logic [ND*W-1:0]   mu_d_q;

    logic [2:0]        i_d;
    logic [2:0]        j_d;
    logic              last_d;

    // Memberships unpacked into 8-entry tables so the 3-bit indices address
    // them directly; entries beyond NT/ND are tied to zero and never selected.
    logic [W-1:0]      mu_t_tab [8];
    logic [W-1:0]      mu_d_tab [8];
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic [W-1:0]      w_tn;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_tab
            if (g < NT) begin : g_t_used
                assign mu_t_tab[g] = mu_t_q[g*W +: W];
            end else begin : g_t_unused
                assign mu_t_tab[g] = '0;
            end
            if (g < ND) begin : g_d_used
                assign mu_d_tab[g] = mu_d_q[g*W +: W];
            end else begin : g_d_unused
                assign mu_d_tab[g] = '0;
            end
        end
    endgenerate

    // Operands come from the captured frame only, never from the live inputs.
    assign w_a = mu_t_tab[i_q];
    assign w_b = mu_d_tab[j_q];

    generate
        if (TNORM == 1) begin : g_prod
            // Full 2W-bit product, upper W bits kept, lower bits truncated.
            assign w_tn = W'(({{W{1'b0}}, w_a} * {{W{1'b0}}, w_b}) >> W);
        end else begin : g_min
            assign w_tn = (w_a < w_b) ? w_a : w_b;
        end
    endgenerate

    // Row-major successor of the current rule index.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (j_q == J_LAST) begin
            j_d = 3'd0;
            i_d = i_q + 3'd1;
        end else begin
            j_d = j_q + 3'd1;
        end
        last_d = (i_d == I_LAST) && (j_d == J_LAST);
    end

    // Indices and the last flag are returned to zero when the frame leaves
    // RUN, so they read 0 in IDLE/SUM without extra gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            i_q         <= 3'd0;
            j_q         <= 3'd0;
            acc_q       <= '0;
            mu_t_q      <= '0;
            mu_d_q      <= '0;
        end else begin
            sum_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mu_t_q      <= mu_t;
                        mu_d_q      <= mu_d;
                        i_q         <= 3'd0;
                        j_q         <= 3'd0;
                        acc_q       <= '0;
                        out_last_q  <= ONE_RULE;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (out_valid_q && out_ready) begin
                        acc_q <= acc_q + SW'(w_tn);
                        if (out_last_q) begin
                            i_q         <= 3'd0;
                            j_q         <= 3'd0;
                            out_last_q  <= 1'b0;
                            out_valid_q <= 1'b0;
                            sum_valid_q <= 1'b1;
                            state_q     <= SUM;
                        end else begin
                            i_q        <= i_d;
                            j_q        <= j_d;
                            out_last_q <= last_d;
                        end
                    end
                end
                SUM: begin
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    i_q         <= 3'd0;
                    j_q         <= 3'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_w     = out_valid_q ? w_tn : '0;
    assign out_i     = i_q;
    assign out_j     = j_q;
    assign out_last  = out_last_q;
    assign sum_valid = sum_valid_q;
    assign w_sum     = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_rules_grid_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rules_grid_seq
//  Description : Self-checking bench for rules_grid_seq. Three instances
//                (3x3 min, 1x1 product, 2x4 min) share one stimulus bus and
//                are selected one at a time; expected weights and sums come
//                from a table of hand-computed vectors and from a reference
//                model evaluated directly from the rule definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rules_grid_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] mt_bus = '0;
    logic [127:0] md_bus = '0;
    int           sel = 0;

    logic [2:0]   iv;
    logic [2:0]   ir, ov, ol, sv;
    logic [15:0]  ow0, ow1, ow2;
    logic [2:0]   oi0, oi1, oi2, oj0, oj1, oj2;
    logic [19:0]  ws0;
    logic [15:0]  ws1;
    logic [18:0]  ws2;

    // view of the selected instance
    logic         m_ir, m_ov, m_ol, m_sv;
    logic [15:0]  m_ow;
    logic [2:0]   m_oi, m_oj;
    logic [19:0]  m_ws;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign iv[0] = in_valid && (sel == 0);
    assign iv[1] = in_valid && (sel == 1);
    assign iv[2] = in_valid && (sel == 2);

    rules_grid_seq #(.W(16), .NT(3), .ND(3), .TNORM(0)) u_min33 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .mu_t(mt_bus[47:0]), .mu_d(md_bus[47:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_w(ow0), .out_i(oi0), .out_j(oj0),
        .out_last(ol[0]), .sum_valid(sv[0]), .w_sum(ws0));

    rules_grid_seq #(.W(16), .NT(1), .ND(1), .TNORM(1)) u_prod11 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .mu_t(mt_bus[15:0]), .mu_d(md_bus[15:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_w(ow1), .out_i(oi1), .out_j(oj1),
        .out_last(ol[1]), .sum_valid(sv[1]), .w_sum(ws1));

    rules_grid_seq #(.W(16), .NT(2), .ND(4), .TNORM(0)) u_min24 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .mu_t(mt_bus[31:0]), .mu_d(md_bus[63:0]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_w(ow2), .out_i(oi2), .out_j(oj2),
        .out_last(ol[2]), .sum_valid(sv[2]), .w_sum(ws2));

    always_comb begin
        m_ir = ir[0]; m_ov = ov[0]; m_ol = ol[0]; m_sv = sv[0];
        m_ow = ow0; m_oi = oi0; m_oj = oj0; m_ws = ws0;
        case (sel)
            1: begin
                m_ir = ir[1]; m_ov = ov[1]; m_ol = ol[1]; m_sv = sv[1];
                m_ow = ow1; m_oi = oi1; m_oj = oj1; m_ws = 20'(ws1);
            end
            2: begin
                m_ir = ir[2]; m_ov = ov[2]; m_ol = ol[2]; m_sv = sv[2];
                m_ow = ow2; m_oi = oi2; m_oj = oj2; m_ws = 20'(ws2);
            end
            default: ;
        endcase
    end

    function automatic int cfg_nt(input int s);
        return (s == 0) ? 3 : (s == 1) ? 1 : 2;
    endfunction
    function automatic int cfg_nd(input int s);
        return (s == 0) ? 3 : (s == 1) ? 1 : 4;
    endfunction
    function automatic int cfg_tn(input int s);
        return (s == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t sel=%0d)", nm, act, exp, $time, sel);
        end
    endtask

    // Reference model: every rule weight from the t-norm definition, plus total.
    function automatic void model(input int s, input logic [127:0] mt, input logic [127:0] md,
                                  output logic [143:0] ew, output logic [19:0] es);
        int nt, nd;
        longint a, b, w, tot;
        nt = cfg_nt(s);
        nd = cfg_nd(s);
        ew = '0;
        tot = 0;
        for (int i = 0; i < nt; i++) begin
            for (int j = 0; j < nd; j++) begin
                a = longint'(16'(mt >> (i * 16)));
                b = longint'(16'(md >> (j * 16)));
                if (cfg_tn(s) == 1) w = (a * b) / 65536;
                else                w = (a < b) ? a : b;
                ew[(i * nd + j) * 16 +: 16] = 16'(w);
                tot += w;
            end
        end
        es = 20'(tot);
    endfunction

    function automatic logic [127:0] rand_mu();
        logic [127:0] v;
        int r;
        v = '0;
        for (int l = 0; l < 8; l++) begin
            r = $urandom_range(0, 7);
            v[l * 16 +: 16] = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
        end
        return v;
    endfunction

    // Runs one frame on instance s. Called at a negedge with that instance
    // idle; returns at the negedge of the first IDLE cycle after SUM.
    // mode 0: ready high, 1: 5-cycle stall on rule (0,1),
    // 2: random ready plus junk in_valid/data during RUN and SUM.
    task automatic run_frame(input int s, input logic [127:0] mt, input logic [127:0] md,
                             input logic [143:0] ew, input logic [19:0] es, input int mode);
        int n, nd, k, cyc, nstall;
        logic hs;
        nd = cfg_nd(s);
        n = cfg_nt(s) * nd;
        sel = s;
        #1;
        cyc = 0;
        while (!m_ir && cyc < 50) begin @(negedge clk); cyc++; end
        chk("in_ready_idle", 32'(m_ir), 32'd1);
        mt_bus = mt;
        md_bus = md;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mt_bus = rand_mu();
        md_bus = rand_mu();
        k = 0; cyc = 0; nstall = 0;
        while (k < n && cyc < 200) begin
            @(negedge clk);
            chk("out_valid_run", 32'(m_ov), 32'd1);
            chk("in_ready_run", 32'(m_ir), 32'd0);
            chk("out_w", 32'(m_ow), 32'(ew[k * 16 +: 16]));
            chk("out_i", 32'(m_oi), 32'(k / nd));
            chk("out_j", 32'(m_oj), 32'(k % nd));
            chk("out_last", 32'(m_ol), 32'(k == n - 1));
            chk("sum_valid_run", 32'(m_sv), 32'd0);
            hs = out_ready;
            @(posedge clk); #1;
            if (hs) k++;
            cyc++;
            case (mode)
                1: begin
                    if (k == 1 && nstall < 5) begin out_ready = 1'b0; nstall++; end
                    else out_ready = 1'b1;
                end
                2: begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    in_valid = 1'($urandom_range(0, 1));
                    mt_bus = rand_mu();
                    md_bus = rand_mu();
                end
                default: out_ready = 1'b1;
            endcase
        end
        if (k < n) chk("frame_timeout", 32'(k), 32'(n));
        if (mode == 2) in_valid = 1'b1;
        @(negedge clk);
        chk("sum_valid", 32'(m_sv), 32'd1);
        chk("w_sum", 32'(m_ws), 32'(es));
        chk("out_valid_sum", 32'(m_ov), 32'd0);
        chk("in_ready_sum", 32'(m_ir), 32'd0);
        chk("out_w_sum", 32'(m_ow), 32'd0);
        chk("out_idx_sum", 32'({m_oi, m_oj, m_ol}), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("sum_valid_pulse", 32'(m_sv), 32'd0);
        chk("in_ready_back", 32'(m_ir), 32'd1);
        chk("w_sum_hold", 32'(m_ws), 32'(es));
        chk("out_valid_idle", 32'(m_ov), 32'd0);
    endtask

    typedef struct packed {
        logic [1:0]   s;
        logic [127:0] mt;
        logic [127:0] md;
        logic [143:0] ew;
        logic [19:0]  es;
        logic [1:0]   mode;
    } vec_t;

    vec_t tab [8];

    initial begin : main
        logic [143:0] ew;
        logic [19:0]  es;
        logic [127:0] mt, md;

        // plan frame, min 3x3
        tab[0] = '{2'd0, 128'({16'hC000, 16'h4000, 16'h0000}), 128'({16'h2000, 16'hFFFF, 16'h8000}),
                   {16'h2000, 16'hC000, 16'h8000, 16'h2000, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0},
                   20'h20000, 2'd0};
        tab[1] = tab[0];
        tab[1].mode = 2'd1;
        tab[2] = '{2'd0, 128'({16'd3, 16'd2, 16'd1}), 128'({16'd1, 16'd2, 16'd3}),
                   {16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1},
                   20'd14, 2'd2};
        tab[3] = '{2'd1, 128'h8000, 128'h8000, 144'h4000, 20'h04000, 2'd0};
        tab[4] = '{2'd1, 128'hFFFF, 128'hFFFF, 144'hFFFE, 20'h0FFFE, 2'd0};
        tab[5] = '{2'd1, 128'h0000, 128'hFFFF, 144'h0000, 20'h00000, 2'd0};
        tab[6] = '{2'd2, 128'({16'hFFFF, 16'hFFFF}), 128'({16'd4, 16'd3, 16'd2, 16'd1}),
                   144'({16'd4, 16'd3, 16'd2, 16'd1, 16'd4, 16'd3, 16'd2, 16'd1}),
                   20'd20, 2'd0};
        tab[7] = '{2'd0, 128'({3{16'hFFFF}}), 128'({3{16'hFFFF}}),
                   {9{16'hFFFF}}, 20'h8FFF7, 2'd2};

        // reset state of every instance
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", 32'(m_ir), 32'd1);
            chk("rst_out_valid", 32'(m_ov), 32'd0);
            chk("rst_out_w", 32'(m_ow), 32'd0);
            chk("rst_idx", 32'({m_oi, m_oj, m_ol}), 32'd0);
            chk("rst_sum_valid", 32'(m_sv), 32'd0);
            chk("rst_w_sum", 32'(m_ws), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_frame(int'(tab[v].s), tab[v].mt, tab[v].md, tab[v].ew, tab[v].es, int'(tab[v].mode));

        // reset after the 4th weight of a frame
        sel = 0;
        #1;
        mt_bus = tab[0].mt;
        md_bus = tab[0].md;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_idx", 32'({m_oi, m_oj}), 32'({3'd1, 3'd1}));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(m_ir), 32'd1);
        chk("mid_rst_out_valid", 32'(m_ov), 32'd0);
        chk("mid_rst_w_sum", 32'(m_ws), 32'd0);
        chk("mid_rst_sum_valid", 32'(m_sv), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_sum_after_rst", 32'({m_sv, m_ov}), 32'd0);
        end
        run_frame(0, tab[0].mt, tab[0].md, tab[0].ew, tab[0].es, 0);

        // random frames against the reference model
        for (int r = 0; r < 18; r++) begin
            mt = rand_mu();
            md = rand_mu();
            model(r % 3, mt, md, ew, es);
            run_frame(r % 3, mt, md, ew, es, (r % 2 == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
